retnuo_cl: RTL and testbench



---
 rtl/retnuo_cl.sv | 65 ++++++
 tb/tb_retnuo_cl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/retnuo_cl.sv
// retnuo_cl: bit-reversal of the Spongent round-counter state.
// Reverses lfsr[WIDTH-1:0] into out[WIDTH-1:0] and zero-fills the upper
// bits. Registered by default with a one-cycle latency.
// Build option RETNUOCL_COMB_EN: out and out_valid become purely
// combinational (out = rev(lfsr), out_valid = en) for in-round use.
//
// Handshake: out_valid is a one-cycle strobe meaning "out holds a fresh
// result this cycle". There is no ready; every en is accepted and the
// consumer must take the result in the strobe cycle.
module retnuo_cl #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] lfsr,
    output logic [15:0] out,
    output logic        out_valid
);

    // Reject illegal widths at elaboration time.
    generate
        if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
            $error("retnuo_cl: WIDTH must be in 1..16");
        end
    endgenerate

    logic [15:0] rev;

    // Pure wiring: reverse the active bits, force the unused upper bits to 0.
    always_comb begin
        rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rev[i] = lfsr[WIDTH-1-i];
        end
    end

`ifdef RETNUOCL_COMB_EN
    // Zero-latency mode: the surrounding core registers the state itself.
    assign out       = rev;
    assign out_valid = en;

    // Clock and reset are intentionally not used in this mode.
    logic unused_comb;
    assign unused_comb = &{1'b0, clk, rst_n};
`else
    // Capture register: reset clears, en loads the reversed value, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (en) begin
                out <= rev;
            end
            out_valid <= en;
        end
    end
`endif

    // Bits of lfsr above WIDTH never reach the output.
    logic unused_lfsr;
    assign unused_lfsr = &{1'b0, lfsr};

endmodule

// File: tb/tb_retnuo_cl.sv
// tb_retnuo_cl: directed bench for retnuo_cl at WIDTH = 16 and WIDTH = 7.
module tb_retnuo_cl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] lfsr;
    logic [15:0] out16;
    logic        v16;
    logic [15:0] out7;
    logic        v7;

    int n_cmp;
    int n_bad;

    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] lfsr;
        logic [15:0] exp16;
        logic [15:0] exp7;
    } vec_t;

    vec_t vecs[10];

    retnuo_cl #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .en(en), .lfsr(lfsr),
        .out(out16), .out_valid(v16)
    );

    retnuo_cl #(.WIDTH(7)) u7 (
        .clk(clk), .rst_n(rst_n), .en(en), .lfsr(lfsr),
        .out(out7), .out_valid(v7)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        lfsr  = '0;
    end

    // Reference reversal built by shifting bits in LSB-first.
    function automatic logic [15:0] ref_rev(input logic [15:0] x, input int w);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r = {r[14:0], x[i]};
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drivers: change inputs on the falling edge, sample #1 after the rising edge.
    task automatic drive(input logic r, input logic e, input logic [15:0] v);
        @(negedge clk);
        rst_n = r;
        en    = e;
        lfsr  = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{16'h0001, 16'h8000, 16'h0040};
        vecs[1] = '{16'h0005, 16'hA000, 16'h0050};
        vecs[2] = '{16'h1234, 16'h2C48, 16'h0016};
        vecs[3] = '{16'hFF81, 16'h81FF, 16'h0040};
        vecs[4] = '{16'h0000, 16'h0000, 16'h0000};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 16'h007F};
        vecs[6] = '{16'h0003, 16'hC000, 16'h0060};
        vecs[7] = '{16'h8000, 16'h0001, 16'h0000};
        vecs[8] = '{16'h0040, 16'h0200, 16'h0001};
        vecs[9] = '{16'hA5C3, 16'hC3A5, 16'h0061};

`ifdef RETNUOCL_COMB_EN
        // Combinational build: results appear without any clock edge.
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            en   = i[0];
            lfsr = vecs[i].lfsr;
            #1;
            check("comb_out16", out16, vecs[i].exp16);
            check("comb_out7", out7, vecs[i].exp7);
            check("comb_valid", {15'b0, v16}, {15'b0, en});
        end
`else
        // Reset with en high and all-ones input must still clear.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 16'hFFFF);
            tick();
            check("rst_out16", out16, 16'h0000);
            check("rst_valid16", {15'b0, v16}, 16'h0000);
            check("rst_out7", out7, 16'h0000);
            check("rst_valid7", {15'b0, v7}, 16'h0000);
        end

        // First capture is taken on the same edge reset releases.
        drive(1'b1, 1'b1, 16'h0001);
        tick();
        check("first_out16", out16, 16'h8000);
        check("first_valid16", {15'b0, v16}, 16'h0001);

        // Table vectors, back to back.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, vecs[i].lfsr);
            tick();
            check("tbl_out16", out16, vecs[i].exp16);
            check("tbl_out7", out7, vecs[i].exp7);
            check("tbl_valid16", {15'b0, v16}, 16'h0001);
            check("tbl_valid7", {15'b0, v7}, 16'h0001);
        end

        // Hold: en low keeps out while lfsr moves; valid drops.
        drive(1'b1, 1'b1, 16'h0003);
        tick();
        check("hold_cap", out16, 16'hC000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 16'h1111 * (i + 1));
            tick();
            check("hold_out16", out16, 16'hC000);
            check("hold_out7", out7, 16'h0060);
            check("hold_valid", {15'b0, v16}, 16'h0000);
        end

        // Mid-stream reset discards the pending capture.
        drive(1'b1, 1'b1, 16'h1234);
        drive(1'b0, 1'b1, 16'h0005);
        tick();
        check("midrst_out16", out16, 16'h0000);
        check("midrst_valid", {15'b0, v16}, 16'h0000);
        drive(1'b1, 1'b1, 16'h0005);
        tick();
        check("after_rst_out16", out16, 16'hA000);

        // Exhaustive sweep, one new value per cycle with en held high.
        for (int v = 0; v < 65536; v++) begin
            drive(1'b1, 1'b1, v[15:0]);
            exp_q.push_back(ref_rev(v[15:0], 16));
            tick();
            check("sweep_out16", out16, exp_q.pop_front());
            check("sweep_out7", out7, ref_rev(v[15:0], 7));
            check("sweep_valid", {15'b0, v16}, 16'h0001);
        end
        drive(1'b1, 1'b0, 16'h0000);
        tick();
        check("sweep_end_valid", {15'b0, v16}, 16'h0000);
        check("sweep_end_hold", out16, 16'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
